// File: rtl/raw_gw_pkg.sv
// Shared types and defaults for the raw_gateway transmit arbiter.
package raw_gw_pkg;

  localparam int unsigned JumboDwDefault = 11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StSend = 2'd2,
    StDone = 2'd3
  } arb_state_e;

endpackage

// File: rtl/raw_tx_arbiter_if.sv
// Client-side and engine-side transmit signals of the arbiter.
interface raw_tx_arbiter_if
  import raw_gw_pkg::*;
#(
  parameter int unsigned cw       = 2,
  parameter int unsigned jumbo_dw = JumboDwDefault
);
  localparam int unsigned n_clients = 2 ** cw;

  logic [n_clients-1:0]          cl_tx_req;
  logic [n_clients*jumbo_dw-1:0] cl_tx_len;
  logic [n_clients*8-1:0]        cl_tx_byte;
  logic [n_clients-1:0]          cl_tx_ack;
  logic [n_clients-1:0]          cl_tx_gate;
  logic                          tx_req;
  logic [jumbo_dw-1:0]           tx_len;
  logic                          tx_ack;
  logic                          tx_gate;
  logic [7:0]                    tx_byte;
  logic [cw-1:0]                 grant_id;
  logic                          busy;
  logic                          err;

  modport slave (
    input  cl_tx_req, cl_tx_len, cl_tx_byte, tx_ack, tx_gate,
    output cl_tx_ack, cl_tx_gate, tx_req, tx_len, tx_byte, grant_id, busy, err
  );

  modport master (
    output cl_tx_req, cl_tx_len, cl_tx_byte, tx_ack, tx_gate,
    input  cl_tx_ack, cl_tx_gate, tx_req, tx_len, tx_byte, grant_id, busy, err
  );

endinterface

// File: rtl/raw_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last_grant+1.
module rr_pick #(
  parameter int unsigned cw = 2
) (
  input  logic [2**cw-1:0] req,
  input  logic [cw-1:0]    last_grant,
  output logic             valid,
  output logic [cw-1:0]    index
);
  localparam int unsigned n_clients = 2 ** cw;

  logic [cw-1:0] cand;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = int'(n_clients); off > 0; off--) begin
      cand = last_grant + cw'(off);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/raw_tx_arbiter.sv
// Round-robin arbiter sharing the raw_gateway transmit engine among 2**cw packet sources.
module raw_tx_arbiter
  import raw_gw_pkg::*;
#(
  parameter int unsigned cw       = 2,
  parameter int unsigned jumbo_dw = JumboDwDefault
) (
  input logic             clk,
  input logic             rst,
  raw_tx_arbiter_if.slave bus
);

  arb_state_e          state_q, state_d;
  logic [cw-1:0]       grant_q, grant_d;
  logic [cw-1:0]       last_q, last_d;
  logic [jumbo_dw-1:0] len_q, len_d;
  logic [jumbo_dw-1:0] cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                pick_valid;
  logic [cw-1:0]       pick_idx;
  logic                gate_ok;

  rr_pick #(.cw(cw)) u_pick (
    .req        (bus.cl_tx_req),
    .last_grant (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // A gate is only legal while bytes of the granted packet remain.
  assign gate_ok = (state_q == StSend) && (cnt_q != len_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = err_q | (bus.tx_gate & ~gate_ok) | (bus.tx_ack & (state_q != StReq));
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          len_d   = bus.cl_tx_len[pick_idx*jumbo_dw +: jumbo_dw];
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.tx_ack) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (cnt_q == len_q) begin
          state_d = StDone;
        end else if (bus.tx_gate) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= {cw{1'b1}};
      len_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.cl_tx_ack  = '0;
    bus.cl_tx_gate = '0;
    if (ack_q) bus.cl_tx_ack[grant_q] = 1'b1;
    if (gate_ok && bus.tx_gate) bus.cl_tx_gate[grant_q] = 1'b1;
  end

  assign bus.tx_req   = (state_q == StReq);
  assign bus.tx_len   = len_q;
  assign bus.tx_byte  = bus.cl_tx_byte[grant_q*8 +: 8];
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_raw_tx_arbiter.sv
// Randomized bench for raw_tx_arbiter with a round-robin grant-order model and byte scoreboard.
module tb_raw_tx_arbiter;
  import raw_gw_pkg::*;

  localparam int cw  = 2;
  localparam int nc  = 4;
  localparam int jdw = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  raw_tx_arbiter_if #(.cw(cw), .jumbo_dw(jdw)) bus ();

  raw_tx_arbiter #(.cw(cw), .jumbo_dw(jdw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #4 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int          want[nc];
  int          cl_len[nc];
  int          byte_idx[nc];
  int          base[nc];
  int          ack_cnt[nc];
  int          gate_cnt[nc];
  logic [nc-1:0] pend_gate;
  logic        byte_due;
  logic [7:0]  bytes_q[$];
  int          model_last;
  int          exp_q[$];

  // Byte k produced by client c; client 0 gives 0x12, 0x21, 0x30, ...
  function automatic logic [7:0] data(input int c, input int k);
    return 8'(c * 64 + k * 15 + 18);
  endfunction

  // Expected grant order: repeatedly pick the nearest client above the last grant still wanting.
  function automatic void predict();
    int left[nc];
    int total = 0;
    exp_q.delete();
    for (int c = 0; c < nc; c++) begin
      left[c] = want[c];
      total += want[c];
    end
    repeat (total) begin
      for (int s = 1; s <= nc; s++) begin
        int c = (model_last + s) % nc;
        if (left[c] > 0) begin
          exp_q.push_back(c);
          left[c]--;
          model_last = c;
          break;
        end
      end
    end
  endfunction

  // One clock cycle: clients and engine drive at the falling edge, observations 1ns later.
  task automatic step(input logic gate, input logic ack);
    @(negedge clk);
    for (int c = 0; c < nc; c++) begin
      if (pend_gate[c]) begin
        bus.cl_tx_byte[c*8 +: 8] = data(c, byte_idx[c]);
        byte_idx[c]++;
      end
      bus.cl_tx_req[c]             = (want[c] > 0);
      bus.cl_tx_len[c*jdw +: jdw]  = jdw'(cl_len[c]);
    end
    bus.tx_gate = gate;
    bus.tx_ack  = ack;
    #1;
    if (byte_due) bytes_q.push_back(bus.tx_byte);
    byte_due  = gate;
    pend_gate = bus.cl_tx_gate;
    for (int c = 0; c < nc; c++) begin
      ack_cnt[c]  += int'(bus.cl_tx_ack[c]);
      gate_cnt[c] += int'(bus.cl_tx_gate[c]);
      if (bus.cl_tx_ack[c] && want[c] > 0) want[c]--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.tx_gate = 1'b0;
    bus.tx_ack  = 1'b0;
    pend_gate   = '0;
    byte_due    = 1'b0;
    model_last  = nc - 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Engine side of one packet: wait for tx_req, ack, issue tx_len gates, wait for idle.
  task automatic serve(input int ack_delay, input int max_gap, input logic extra,
                       output int g, output int l, output int req_wait, output int idle_lat);
    for (int c = 0; c < nc; c++) begin
      ack_cnt[c]  = 0;
      gate_cnt[c] = 0;
      base[c]     = byte_idx[c];
    end
    bytes_q.delete();
    g = -1; l = -1; req_wait = 0; idle_lat = 0;
    do begin
      step(1'b0, 1'b0);
      if (!bus.tx_req) req_wait++;
    end while (!bus.tx_req && req_wait < 50);
    if (!bus.tx_req) begin
      n_cmp++; n_fail++;
      $display("FAIL tx_req_timeout: tx_req=%0b after %0d cycles, required 1", bus.tx_req,
               req_wait);
      return;
    end
    g = int'(bus.grant_id);
    l = int'(bus.tx_len);
    repeat (ack_delay) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int k = 0; k < l; k++) begin
      repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    if (extra) step(1'b1, 1'b0);
    do begin
      step(1'b0, 1'b0);
      idle_lat++;
    end while (bus.busy && idle_lat < 100);
    if (bus.busy) begin
      n_cmp++; n_fail++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 0", bus.busy, idle_lat);
      g = -1;
    end
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    @(negedge clk);
    #1;
    obs = {bus.tx_req, bus.tx_len, bus.cl_tx_ack, bus.cl_tx_gate, bus.busy, bus.err, bus.grant_id};
    n_cmp++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 000000", obs);
    end
    rst = 1'b0;
    step(1'b0, 1'b0);
    obs = {bus.tx_req, bus.tx_len, bus.cl_tx_ack, bus.cl_tx_gate, bus.busy, bus.err, bus.grant_id};
    n_cmp++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h, required 000000", obs);
    end
  endtask

  task automatic test_single();
    int g, l, rw, il;
    want[0] = 1; cl_len[0] = 72;
    predict();
    serve(5, 0, 1'b0, g, l, rw, il);
    if (g < 0) return;
    n_cmp++;
    if (g !== 0 || l !== 72) begin
      n_fail++;
      $display("FAIL single_grant: got id=%0d len=%0d, required id=0 len=72", g, l);
    end
    n_cmp++;
    if (rw !== 1) begin
      n_fail++;
      $display("FAIL single_req_latency: got %0d cycles, required 1", rw);
    end
    n_cmp++;
    if (ack_cnt[0] !== 1 || gate_cnt[0] !== 72) begin
      n_fail++;
      $display("FAIL single_pulses: got ack=%0d gates=%0d, required ack=1 gates=72", ack_cnt[0],
               gate_cnt[0]);
    end
    n_cmp++;
    if (bytes_q.size() !== 72) begin
      n_fail++;
      $display("FAIL single_byte_count: got %0d, required 72", bytes_q.size());
    end
    for (int k = 0; k < bytes_q.size() && k < 72; k++) begin
      n_cmp++;
      if (bytes_q[k] !== data(0, base[0] + k)) begin
        n_fail++;
        $display("FAIL single_byte[%0d]: got %h, required %h", k, bytes_q[k],
                 data(0, base[0] + k));
      end
    end
    n_cmp++;
    if (il !== 3 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_finish: got idle_lat=%0d err=%0b, required 3 and 0", il, bus.err);
    end
  endtask

  // mode 0: clients 1,2 together after reset; 1: all four for 3 rounds; 2: random mixes.
  task automatic test_arbitration(input int mode);
    int iters = (mode == 2) ? 6 : 1;
    for (int it = 0; it < iters; it++) begin
      if (mode == 0) begin
        do_reset();
        want[1] = 1; cl_len[1] = 8;
        want[2] = 1; cl_len[2] = 16;
      end else begin
        for (int c = 0; c < nc; c++) begin
          want[c]   = (mode == 1) ? 3 : int'($urandom_range(2, 0));
          cl_len[c] = int'($urandom_range(20, (mode == 1) ? 1 : 0));
        end
        if (want[it % nc] == 0) want[it % nc] = 1;
      end
      predict();
      for (int p = 0; p < exp_q.size(); p++) begin
        int g, l, rw, il, e, others;
        e = exp_q[p];
        serve(int'($urandom_range(4, 0)), (mode == 0) ? 0 : 2, 1'b0, g, l, rw, il);
        if (g < 0) return;
        n_cmp++;
        if (g !== e || l !== cl_len[e]) begin
          n_fail++;
          $display("FAIL arb%0d_pkt%0d_grant: got id=%0d len=%0d, required id=%0d len=%0d", mode,
                   p, g, l, e, cl_len[e]);
        end
        others = 0;
        for (int c = 0; c < nc; c++) if (c != e) others += ack_cnt[c] + gate_cnt[c];
        n_cmp++;
        if (ack_cnt[e] !== 1 || gate_cnt[e] !== cl_len[e] || others !== 0) begin
          n_fail++;
          $display("FAIL arb%0d_pkt%0d_route: got ack=%0d gates=%0d stray=%0d, required 1 %0d 0",
                   mode, p, ack_cnt[e], gate_cnt[e], others, cl_len[e]);
        end
        n_cmp++;
        if (bytes_q.size() !== cl_len[e]) begin
          n_fail++;
          $display("FAIL arb%0d_pkt%0d_nbytes: got %0d, required %0d", mode, p, bytes_q.size(),
                   cl_len[e]);
        end
        for (int k = 0; k < bytes_q.size() && k < cl_len[e]; k++) begin
          n_cmp++;
          if (bytes_q[k] !== data(e, base[e] + k)) begin
            n_fail++;
            $display("FAIL arb%0d_pkt%0d_byte[%0d]: got %h, required %h", mode, p, k, bytes_q[k],
                     data(e, base[e] + k));
          end
        end
      end
      n_cmp++;
      if (bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL arb%0d_err: got %0b, required 0", mode, bus.err);
      end
    end
  endtask

  task automatic test_zero_len();
    int g, l, rw, il, gsum;
    want[3] = 1; cl_len[3] = 0;
    predict();
    serve(2, 0, 1'b0, g, l, rw, il);
    if (g < 0) return;
    gsum = 0;
    for (int c = 0; c < nc; c++) gsum += gate_cnt[c];
    n_cmp++;
    if (g !== 3 || l !== 0 || ack_cnt[3] !== 1 || gsum !== 0) begin
      n_fail++;
      $display("FAIL zero_len: got id=%0d len=%0d ack=%0d gates=%0d, required 3 0 1 0", g, l,
               ack_cnt[3], gsum);
    end
    n_cmp++;
    if (il !== 3 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_idle: got idle_lat=%0d err=%0b, required 3 and 0", il, bus.err);
    end
  endtask

  task automatic test_errors();
    int g, l, rw, il;
    for (int c = 0; c < nc; c++) ack_cnt[c] = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    n_cmp++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || ack_cnt[3] + ack_cnt[0] !== 0) begin
      n_fail++;
      $display("FAIL err_ack_idle: got err=%0b busy=%0b, required err=1 busy=0", bus.err,
               bus.busy);
    end
    do_reset();
    #1;
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: got %0b, required 0", bus.err);
    end
    want[1] = 1; cl_len[1] = 8;
    predict();
    serve(1, 1, 1'b1, g, l, rw, il);
    if (g < 0) return;
    n_cmp++;
    if (gate_cnt[1] !== 8 || gate_cnt[0] + gate_cnt[2] + gate_cnt[3] !== 0) begin
      n_fail++;
      $display("FAIL err_extra_gate_route: got gates=%0d, required 8", gate_cnt[1]);
    end
    repeat (5) step(1'b0, 1'b0);
    n_cmp++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %0b, required 1", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    int g, l, rw, il, n;
    logic [23:0] obs;
    want[0] = 1; cl_len[0] = 72;
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (!bus.tx_req && n < 50);
    step(1'b0, 1'b1);
    repeat (30) step(1'b1, 1'b0);
    want[0] = 1;
    @(negedge clk);
    rst         = 1'b1;
    bus.tx_gate = 1'b0;
    #1;
    obs = {bus.tx_req, bus.tx_len, bus.cl_tx_ack, bus.cl_tx_gate, bus.busy, bus.err, bus.grant_id};
    n_cmp++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h, required 000000", obs);
    end
    pend_gate  = '0;
    byte_due   = 1'b0;
    model_last = nc - 1;
    @(negedge clk);
    rst = 1'b0;
    predict();
    serve(3, 0, 1'b0, g, l, rw, il);
    if (g < 0) return;
    n_cmp++;
    if (g !== 0 || l !== 72 || gate_cnt[0] !== 72) begin
      n_fail++;
      $display("FAIL mid_reset_regrant: got id=%0d len=%0d gates=%0d, required 0 72 72", g, l,
               gate_cnt[0]);
    end
    for (int k = 0; k < bytes_q.size() && k < 72; k++) begin
      n_cmp++;
      if (bytes_q[k] !== data(0, base[0] + k)) begin
        n_fail++;
        $display("FAIL mid_reset_byte[%0d]: got %h, required %h", k, bytes_q[k],
                 data(0, base[0] + k));
      end
    end
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_err: got %0b, required 0", bus.err);
    end
  endtask

  initial begin
    bus.cl_tx_req  = '0;
    bus.cl_tx_len  = '0;
    bus.cl_tx_byte = '0;
    bus.tx_gate    = 1'b0;
    bus.tx_ack     = 1'b0;
    pend_gate      = '0;
    byte_due       = 1'b0;
    model_last     = nc - 1;
    for (int c = 0; c < nc; c++) begin
      want[c] = 0; cl_len[c] = 0; byte_idx[c] = 0; base[c] = 0;
      ack_cnt[c] = 0; gate_cnt[c] = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_arbitration(0);
    test_arbitration(1);
    test_arbitration(2);
    test_zero_len();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/raw_tx_arbiter.md
Name: raw_tx_arbiter

Overview:
- Shares the single transmit side of raw_gateway's packet engine (tx_req/tx_len/tx_ack/tx_gate/tx_byte) among 2**cw local packet sources.
- Uses round-robin arbitration and holds each grant for a whole packet.
- Forwards the winner's request and length upstream, returns ack and gate to the winner only, and muxes the winner's byte stream back to the engine.
- Sits between the client packet builders and the Ethernet/UDP transmit engine.

Parameters:
- cw, 2, client index width; n_clients = 2**cw.
- jumbo_dw, 11, packet length width in bytes, matching raw_gateway.

Ports:
- clk  in  1  system clock (125 MHz, one byte per cycle)
- rst  in  1  asynchronous, active-high reset
- cl_tx_req  in  2**cw  per-client transmit request; level, held until that client's cl_tx_ack
- cl_tx_len  in  2**cw*jumbo_dw  packed lengths; client i at [i*jumbo_dw+:jumbo_dw]; stable while cl_tx_req is high
- cl_tx_byte  in  2**cw*8  packed client bytes; client i at [i*8+:8]
- cl_tx_ack  out  2**cw  one-cycle acknowledge to the granted client
- cl_tx_gate  out  2**cw  tx_gate routed to the granted client only
- tx_req  out  1  request to the transmit engine
- tx_len  out  jumbo_dw  latched length of the granted packet
- tx_ack  in  1  engine acknowledge pulse
- tx_gate  in  1  engine byte strobe; engine samples tx_byte one cycle after tx_gate
- tx_byte  out  8  muxed byte from the granted client
- grant_id  out  cw  index of the current or last granted client
- busy  out  1  high in every state except IDLE
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous): state=IDLE; last_grant=2**cw-1, so client 0 has first priority. All outputs are 0: tx_req, tx_len, cl_tx_ack, busy, err, grant_id.
- States: IDLE -> REQ -> SEND -> DONE -> IDLE.
- IDLE:
  - If any cl_tx_req bit is set, the round-robin picker chooses the first requester, searching upward from last_grant+1 modulo 2**cw.
  - On the same edge, latch grant_id and tx_len from that client's cl_tx_len, and go to REQ.
  - tx_req rises in the cycle after the request is seen (1-cycle latency).
- REQ:
  - tx_req=1 and tx_len is held.
  - On tx_ack=1: clear tx_req on the next edge, pulse cl_tx_ack[grant_id] for exactly one cycle, clear byte_cnt, and go to SEND.
  - A client that drops cl_tx_req during REQ does not withdraw the request: the engine request cannot be retracted, and the packet proceeds.
- SEND:
  - cl_tx_gate = tx_gate one-hot at grant_id, combinational (zero latency).
  - byte_cnt (jumbo_dw bits) increments on every tx_gate.
  - When byte_cnt==tx_len (checked before increment), go to DONE. A tx_len of 0 therefore exits SEND on the first cycle with no gates.
- DONE:
  - Lasts one cycle so the final byte, sampled one cycle after its gate, still comes from the granted client.
  - last_grant<=grant_id; go to IDLE.
  - A new arbitration can therefore begin 1 cycle after DONE.
- tx_byte = cl_tx_byte[grant_id], combinational. grant_id stays stable from the IDLE latch through DONE and holds its value in IDLE, so tx_byte is defined one cycle after the last gate.
- cl_tx_gate is 0 in every state except SEND.
- err is set (sticky until rst) on any of:
  - tx_gate while not in SEND;
  - tx_gate in SEND after byte_cnt has reached tx_len;
  - tx_ack while not in REQ.
  The offending strobe is otherwise ignored and never forwarded.
- Simultaneous requests: exactly one grant per arbitration. A client keeping cl_tx_req high receives at most one grant per round while others are waiting.
- A requester arriving during REQ, SEND or DONE waits for IDLE; it is not lost.
- Reset mid-packet: everything returns to the reset values immediately; any partial packet is abandoned and recovery is the engine's responsibility.

Decomposition:
- Package raw_gw_pkg holds:
  - the state encoding constants (IDLE=0, REQ=1, SEND=2, DONE=3);
  - the default jumbo_dw=11.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: request vector, last_grant.
  - Outputs: valid, index.
  - Parameterised by cw.

Test Plan:
1. Client 0 only, len=72, engine acks 5 cycles later, then 72 gates -> tx_len=72; one cl_tx_ack[0] pulse; 72 cl_tx_gate[0] pulses; tx_byte equals client 0 bytes (e.g. 0x12,0x21,...); busy falls after DONE; err=0.
2. Clients 1 and 2 request in the same cycle (len 8 and 16) after reset -> client 1 served first (grant_id=1, tx_len=8), then client 2 (tx_len=16); no gate reaches the non-granted client.
3. All 4 clients hold requests for 3 rounds -> grant order 0,1,2,3,0,1,2,3,0,1,2,3.
4. Client 3 with len=0 -> tx_req, cl_tx_ack[3], no gates needed; back to IDLE 2 cycles after ack; err=0.
5. Extra tx_gate after the 8th byte of a len=8 packet, and a tx_ack in IDLE -> err=1 and stays high; no extra cl_tx_gate.
6. Assert rst for 1 cycle at byte 30 of a len=72 SEND -> all outputs 0 asynchronously. With the request still held, client 0 is re-granted (grant_id=0, tx_len=72) once rst drops.
